// File: rtl/rotate_pkg.sv
// Shared constants, FSM state type and rho offset table for the rotate sequencer.
package rotate_pkg;

  localparam int unsigned LANES      = 25;
  localparam int unsigned LANE_IDX_W = 5;
  localparam int unsigned W_DEFAULT  = 64;
  localparam int unsigned WB_DEFAULT = 6;
  localparam int unsigned RHO_W      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } rot_state_e;

  // Rotation offsets indexed by lane = x + 5*y
  localparam logic [RHO_W-1:0] RHO [LANES] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  // Safe table lookup; lane codes beyond the last lane read as zero
  function automatic logic [RHO_W-1:0] rho_of(input logic [LANE_IDX_W-1:0] lane);
    logic [RHO_W-1:0] r;
    r = '0;
    if (lane < LANE_IDX_W'(LANES)) r = RHO[lane];
    return r;
  endfunction

endpackage

// File: rtl/rotate_addr_gen.sv
// Slice-major lane/bit counters and source-bit address for the rotate pass.
module rotate_addr_gen
  import rotate_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned WB = WB_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  step_i,
  output logic [LANE_IDX_W-1:0] c25_o,
  output logic [WB-1:0]         c64_o,
  output logic [WB-1:0]         rd_bit_o,
  output logic                  last_c_o
);

  localparam logic [LANE_IDX_W-1:0] LANE_LAST = LANE_IDX_W'(LANES - 1);
  localparam logic [WB-1:0]         BIT_LAST  = WB'(W - 1);

  logic [LANE_IDX_W-1:0] c25_q, c25_d;
  logic [WB-1:0]         c64_q, c64_d;
  logic [WB-1:0]         rd_bit_q, rd_bit_d;

  // Next counter values; source bit is precomputed from them so it leaves a flop
  always_comb begin
    c25_d = c25_q;
    c64_d = c64_q;
    if (clear_i) begin
      c25_d = '0;
      c64_d = '0;
    end else if (step_i) begin
      if (c25_q == LANE_LAST) begin
        c25_d = '0;
        c64_d = c64_q + WB'(1);
      end else begin
        c25_d = c25_q + LANE_IDX_W'(1);
      end
    end
    // Wraps in WB bits, which is the mod-W reduction for W = 2**WB
    rd_bit_d = c64_d - WB'(rho_of(c25_d));
  end

  // Counter and address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      c25_q    <= '0;
      c64_q    <= '0;
      rd_bit_q <= '0;
    end else begin
      c25_q    <= c25_d;
      c64_q    <= c64_d;
      rd_bit_q <= rd_bit_d;
    end
  end

  assign c25_o    = c25_q;
  assign c64_o    = c64_q;
  assign rd_bit_o = rd_bit_q;
  assign last_c_o = step_i & (c25_q == LANE_LAST) & (c64_q == BIT_LAST);

endmodule

// File: rtl/rotate_controller.sv
// Rotate (rho) pass sequencer: read one source bit per cycle, write it one cycle later.
// Optional build macro ROTATE_CTRL_STALL_EN adds a stall input that freezes the read side.
module rotate_controller
  import rotate_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned WB = WB_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef ROTATE_CTRL_STALL_EN
  input  logic                  stall,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [LANE_IDX_W-1:0] rd_lane,
  output logic [WB-1:0]         rd_bit,
  input  logic                  rd_data,
  output logic                  en,
  output logic [LANE_IDX_W-1:0] wr_lane,
  output logic [WB-1:0]         wr_bit,
  output logic                  pin,
  output logic                  co_c25,
  output logic                  co_c64
);

  localparam logic [LANE_IDX_W-1:0] LANE_LAST = LANE_IDX_W'(LANES - 1);
  localparam logic [WB-1:0]         BIT_LAST  = WB'(W - 1);

  rot_state_e            state_q;
  logic                  run_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  en_q;
  logic [LANE_IDX_W-1:0] wr_lane_q;
  logic [WB-1:0]         wr_bit_q;
  logic                  co_c25_q;
  logic                  co_c64_q;

  logic                  stall_w;
  logic                  step;
  logic                  clear;
  logic                  last_c;
  logic [LANE_IDX_W-1:0] c25;
  logic [WB-1:0]         c64;

`ifdef ROTATE_CTRL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign step  = run_q & ~stall_w;
  assign clear = (state_q == IDLE) & start;

  rotate_addr_gen #(
    .W  (W),
    .WB (WB)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .step_i   (step),
    .c25_o    (c25),
    .c64_o    (c64),
    .rd_bit_o (rd_bit),
    .last_c_o (last_c)
  );

  // Pass sequencing: IDLE -> RUN (1600 reads) -> FLUSH (last write) -> DONE (pulse)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            run_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (last_c) begin
            state_q <= FLUSH;
            run_q   <= 1'b0;
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          run_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write stage: read strobe and destination address delayed to match memory latency
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      wr_lane_q <= '0;
      wr_bit_q  <= '0;
      co_c25_q  <= 1'b0;
      co_c64_q  <= 1'b0;
    end else begin
      en_q      <= step;
      wr_lane_q <= c25;
      wr_bit_q  <= c64;
      co_c25_q  <= step & (c25 == LANE_LAST);
      co_c64_q  <= step & (c64 == BIT_LAST);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = step;
  assign rd_lane = c25;
  assign en      = en_q;
  assign wr_lane = wr_lane_q;
  assign wr_bit  = wr_bit_q;
  assign co_c25  = co_c25_q;
  assign co_c64  = co_c64_q;
  // Read data passes straight through; gated so it is quiet outside write cycles
  assign pin     = rd_data & en_q;

endmodule

// File: tb/tb_rotate_controller.sv
// Self-checking bench for rotate_controller (W = 64): scoreboard of rho writes plus address vectors.
`timescale 1ns/1ps
module tb_rotate_controller;

  localparam int W     = 64;
  localparam int LANES = 25;
  localparam int NBITS = 1600;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rd_data;
`ifdef ROTATE_CTRL_STALL_EN
  logic       stall;
`endif
  logic       busy, done, rd_en, en, pin, co_c25, co_c64;
  logic [4:0] rd_lane, wr_lane;
  logic [5:0] rd_bit, wr_bit;

  always #5 clk = ~clk;

  rotate_controller dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef ROTATE_CTRL_STALL_EN
    .stall   (stall),
`endif
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_lane (rd_lane),
    .rd_bit  (rd_bit),
    .rd_data (rd_data),
    .en      (en),
    .wr_lane (wr_lane),
    .wr_bit  (wr_bit),
    .pin     (pin),
    .co_c25  (co_c25),
    .co_c64  (co_c64)
  );

  // State memory with one-cycle read latency
  logic [W-1:0] mem [LANES];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_lane][rd_bit] : 1'b0;

  int rho_t [LANES] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                        41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  typedef struct { int lane; int bitx; logic data; } wr_exp_t;
  typedef struct { int c64; int lane; int exp_bit; } addr_vec_t;

  wr_exp_t    exp_q [$];
  addr_vec_t  vecs [6];
  logic [4:0] log_lane [NBITS];
  logic [5:0] log_bit  [NBITS];

  int tests = 0, fails = 0, cyc = 0;
  int en_cnt, c25_cnt, both_cnt, both_at, done_cnt, done_cyc, last_en_cyc, rd_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observe one cycle: scoreboard writes, log reads, count strobes
  task automatic sample();
    if (en) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_write", 32'd1, 32'd0);
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        check("sb_write", {wr_lane, wr_bit, pin, co_c25, co_c64},
              {5'(e.lane), 6'(e.bitx), e.data, (e.lane == 24), (e.bitx == 63)});
      end
      en_cnt++;
      last_en_cyc = cyc;
      if (co_c25) c25_cnt++;
      if (co_c25 && co_c64) begin
        both_cnt++;
        both_at = en_cnt;
      end
    end
    if (rd_en) begin
      if (rd_cnt < NBITS) begin
        log_lane[rd_cnt] = rd_lane;
        log_bit[rd_cnt]  = rd_bit;
      end
      rd_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  // Fresh random state and the reference rho result in write order
  task automatic load_pass();
    for (int l = 0; l < LANES; l++) mem[l] = {$urandom(), $urandom()};
    exp_q.delete();
    en_cnt = 0; c25_cnt = 0; both_cnt = 0; both_at = 0;
    done_cnt = 0; done_cyc = 0; last_en_cyc = 0; rd_cnt = 0;
    for (int b = 0; b < W; b++)
      for (int l = 0; l < LANES; l++) begin
        int src;
        src = (b - rho_t[l] + W) % W;
        exp_q.push_back('{l, b, mem[l][src]});
      end
  endtask

  task automatic run_pass(input int pulse_at, input bit pulse_in_done, input int rst_at,
                          input int stall_at, input int stall_len,
                          output int latency, output bit aborted);
    int s, run_cyc, stall_bad, busy_seen;
    logic [10:0] frz;
    latency = -1; aborted = 1'b0; stall_bad = 0; busy_seen = 0; frz = '0;
    load_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    check("busy_after_e0", {31'd0, busy}, 32'd1);
    check("first_read_addr", {rd_en, rd_lane, rd_bit}, {1'b1, 5'd0, 6'd0});
    run_cyc = 1;
    while (done_cnt == 0 && !aborted && run_cyc < 4000) begin
      start = (run_cyc == pulse_at);
      rst   = (run_cyc == rst_at);
`ifdef ROTATE_CTRL_STALL_EN
      if (run_cyc == stall_at) frz = {rd_lane, rd_bit};
      stall = (stall_len > 0) && (run_cyc >= stall_at) && (run_cyc < stall_at + stall_len);
`endif
      tick();
      run_cyc++;
`ifdef ROTATE_CTRL_STALL_EN
      if (stall && (rd_en || ({rd_lane, rd_bit} != frz))) stall_bad++;
`endif
      if (rst) begin
        aborted = 1'b1;
        rst = 1'b0;
        check("rst_outputs_zero",
              {busy, done, rd_en, rd_lane, rd_bit, en, wr_lane, wr_bit, pin, co_c25, co_c64}, '0);
      end
    end
    start = 1'b0;
`ifdef ROTATE_CTRL_STALL_EN
    stall = 1'b0;
    if (stall_len > 0) check("stall_rd_quiet", stall_bad, 0);
`endif
    if (!aborted && done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    if (done_cnt != 0) latency = done_cyc - s;
    if (done_cnt != 0 && pulse_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_cleared", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy) busy_seen++;
    end
    check("stays_idle", busy_seen, 0);
    check("done_pulses", done_cnt, aborted ? 0 : 1);
  endtask

  task automatic post_checks(input int latency, input int exp_latency);
    check("en_pulses", en_cnt, NBITS);
    check("co_c25_pulses", c25_cnt, 64);
    check("co_both_once", both_cnt, 1);
    check("co_both_on_last", both_at, NBITS);
    check("done_after_last_en", done_cyc - last_en_cyc, 1);
    check("done_latency", latency, exp_latency);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int  lat;
    bit  ab;
    int  bad;
    rst = 1'b1; start = 1'b0;
`ifdef ROTATE_CTRL_STALL_EN
    stall = 1'b0;
`endif
    vecs[0] = '{0, 2, 2};
    vecs[1] = '{0, 1, 63};
    vecs[2] = '{5, 0, 5};
    vecs[3] = '{5, 24, 55};
    vecs[4] = '{0, 0, 0};
    vecs[5] = '{63, 24, 49};

    for (int i = 0; i < 3; i++) tick();
    check("reset_outputs_zero",
          {busy, done, rd_en, rd_lane, rd_bit, en, wr_lane, wr_bit, pin, co_c25, co_c64}, '0);
    rst = 1'b0;
    tick();

    // Plain pass with address checks
    run_pass(-1, 1'b0, -1, -1, 0, lat, ab);
    post_checks(lat, 1601);
    check("read_count", rd_cnt, NBITS);
    for (int i = 0; i < 6; i++) begin
      int k;
      k = vecs[i].c64 * LANES + vecs[i].lane;
      check("addr_vec", {log_lane[k], log_bit[k]}, {5'(vecs[i].lane), 6'(vecs[i].exp_bit)});
    end
    bad = 0;
    for (int k = 0; k < NBITS; k++) begin
      int l, c;
      l = k % LANES;
      c = k / LANES;
      if (log_lane[k] != 5'(l) || log_bit[k] != 6'((c - rho_t[l] + W) % W)) bad++;
    end
    check("addr_sweep", bad, 0);

    // Start pulses mid-RUN and in DONE are ignored
    run_pass(100, 1'b1, -1, -1, 0, lat, ab);
    post_checks(lat, 1601);

    // Synchronous reset mid-pass aborts without done
    run_pass(-1, 1'b0, 700, -1, 0, lat, ab);
    check("abort_taken", {31'd0, ab}, 32'd1);

    // Fresh pass after abort completes normally
    run_pass(-1, 1'b0, -1, -1, 0, lat, ab);
    post_checks(lat, 1601);

`ifdef ROTATE_CTRL_STALL_EN
    // Ten stalled RUN cycles push completion out by ten
    run_pass(-1, 1'b0, -1, 300, 10, lat, ab);
    post_checks(lat, 1611);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
